// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-locked round-robin arbiter that merges N AXI-Stream
// sources onto one registered output stage tagged with the source index.
// A source keeps the grant from its first accepted beat until its tlast beat
// is accepted. The search for the next grant starts just after the last
// packet's owner. An IDLE cycle between packets is used to arbitrate.
module axis_rr_arbiter #(
  parameter int DW = 24,
  parameter int N  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N*DW-1:0]           s_axis_tdata,
  input  logic [N-1:0]              s_axis_tvalid,
  input  logic [N-1:0]              s_axis_tlast,
  output logic [N-1:0]              s_axis_tready,
  output logic [DW-1:0]             m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] m_axis_tid,
  input  logic                      m_axis_tready,
  output logic                      busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic [DW-1:0]   m_tdata_q, m_tdata_d;
  logic            m_tlast_q, m_tlast_d;
  logic [IW-1:0]   m_tid_q, m_tid_d;
  logic            m_tvalid_q, m_tvalid_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            g_valid;
  logic [DW-1:0]   g_data;
  logic            g_last;
  logic            can_load;
  logic            accept;
  logic [N-1:0]    ready;

  // Round-robin search: first valid source at offset 1..N from last_grant.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!pick_found && s_axis_tvalid[i] &&
            ((int'(last_grant_q) + k) % N == i)) begin
          pick_found = 1'b1;
          pick_idx   = IW'(i);
        end
      end
    end
  end

  // Select the granted source's beat and drive its ready; all others stay low.
  always_comb begin
    g_valid  = 1'b0;
    g_data   = '0;
    g_last   = 1'b0;
    ready    = '0;
    // The output register can take a beat when empty or draining this cycle.
    can_load = !m_tvalid_q || m_axis_tready;
    for (int i = 0; i < N; i++) begin
      if (grant_q == IW'(i)) begin
        g_valid = s_axis_tvalid[i];
        g_data  = s_axis_tdata[i*DW +: DW];
        g_last  = s_axis_tlast[i];
        if (state_q == BUSY) begin
          ready[i] = can_load;
        end
      end
    end
    accept = (state_q == BUSY) && g_valid && can_load;
  end

  // Next-state logic for the grant FSM and the output register.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m_tdata_d    = m_tdata_q;
    m_tlast_d    = m_tlast_q;
    m_tid_d      = m_tid_q;
    m_tvalid_d   = m_tvalid_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // The grant is held through tvalid gaps; only an accepted tlast releases it.
        if (accept && g_last) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A load wins over a drain so packets stream without bubbles.
    if (accept) begin
      m_tdata_d  = g_data;
      m_tlast_d  = g_last;
      m_tid_d    = grant_q;
      m_tvalid_d = 1'b1;
    end else if (m_tvalid_q && m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  // State and output registers; reset discards any in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(N - 1);
      m_tdata_q    <= '0;
      m_tlast_q    <= 1'b0;
      m_tid_q      <= '0;
      m_tvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_tdata_q    <= m_tdata_d;
      m_tlast_q    <= m_tlast_d;
      m_tid_q      <= m_tid_d;
      m_tvalid_q   <= m_tvalid_d;
    end
  end

  assign s_axis_tready = ready;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tid    = m_tid_q;
  assign busy          = (state_q == BUSY);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed testbench for axis_rr_arbiter (DW=24, N=4).
module tb_axis_rr_arbiter;

  localparam int DW = 24;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic [IW-1:0]   m_tid;
  logic            m_tready;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  // Source packet tables
  logic [DW-1:0] pk_data [N][16];
  logic          pk_last [N][16];
  int            pk_len  [N];
  int            pk_ptr  [N];
  int            acc_cnt [N];
  int            gap_at  [N];
  int            gap_len [N];
  int            gap_left[N];
  logic [3:0]    mr_pat;
  int            rst_cycle;

  // Per-cycle log
  logic          lg_mv  [64];
  logic [DW-1:0] lg_md  [64];
  logic          lg_ml  [64];
  logic [IW-1:0] lg_tid [64];
  logic          lg_busy[64];
  logic [N-1:0]  lg_sr  [64];
  logic          lg_mr  [64];

  // Output beats seen at the downstream handshake
  logic [DW-1:0] out_data[64];
  logic [IW-1:0] out_tid [64];
  logic          out_last[64];
  int            out_cyc [64];
  int            out_n;

  axis_rr_arbiter #(.DW(DW), .N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tid    (m_tid),
    .m_axis_tready (m_tready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      pk_len[i] = 0; pk_ptr[i] = 0; acc_cnt[i] = 0;
      gap_at[i] = -1; gap_len[i] = 0; gap_left[i] = 0;
    end
    mr_pat    = 4'hF;
    rst_cycle = -1;
    out_n     = 0;
    s_tvalid  = '0;
    s_tlast   = '0;
    s_tdata   = '0;
    m_tready  = 1'b1;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic add_beat(input int p, input logic [DW-1:0] d, input logic l);
    pk_data[p][pk_len[p]] = d;
    pk_last[p][pk_len[p]] = l;
    pk_len[p]++;
  endtask

  // Drive sources from the packet tables for n cycles, logging outputs mid-cycle.
  task automatic run_cycles(input int n);
    logic [N-1:0] acc;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pk_ptr[i] < pk_len[i] && gap_left[i] == 0) begin
          s_tvalid[i]          = 1'b1;
          s_tdata[i*DW +: DW]  = pk_data[i][pk_ptr[i]];
          s_tlast[i]           = pk_last[i][pk_ptr[i]];
        end else begin
          s_tvalid[i]          = 1'b0;
          s_tdata[i*DW +: DW]  = '0;
          s_tlast[i]           = 1'b0;
        end
      end
      m_tready = mr_pat[2'(c % 4)];
      rst      = (c == rst_cycle);
      @(negedge clk);
      if (c < 64) begin
        lg_mv[c] = m_tvalid; lg_md[c] = m_tdata; lg_ml[c] = m_tlast;
        lg_tid[c] = m_tid; lg_busy[c] = busy; lg_sr[c] = s_tready; lg_mr[c] = m_tready;
      end
      acc = s_tvalid & s_tready;
      if (m_tvalid && m_tready && out_n < 64) begin
        out_data[out_n] = m_tdata; out_tid[out_n] = m_tid;
        out_last[out_n] = m_tlast; out_cyc[out_n] = c;
        out_n++;
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (gap_left[i] > 0) gap_left[i]--;
        if (rst) begin
          pk_ptr[i] = pk_len[i];
        end else if (acc[i]) begin
          pk_ptr[i]++;
          acc_cnt[i]++;
          if (acc_cnt[i] == gap_at[i]) gap_left[i] = gap_len[i];
        end
      end
    end
    rst      = 1'b0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst      = 1'b1;
    s_tvalid = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (s_tready !== 4'h0) begin failures++; $display("FAIL reset_sready_in_rst: got %h expected 0", s_tready); end
    rst = 1'b0;
    s_tvalid = '0;
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_mvalid: got %b expected 0", m_tvalid); end
    checks++;
    if (m_tdata !== 24'h0) begin failures++; $display("FAIL reset_mdata: got %h expected 0", m_tdata); end
    checks++;
    if (m_tlast !== 1'b0 || m_tid !== 2'd0) begin failures++; $display("FAIL reset_mlast_tid: got %b/%0d expected 0/0", m_tlast, m_tid); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_source();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 24'h000011; exp_d[1] = 24'h000022; exp_d[2] = 24'h000033;
    do_reset();
    add_beat(2, 24'h000011, 1'b0);
    add_beat(2, 24'h000022, 1'b0);
    add_beat(2, 24'h000033, 1'b1);
    run_cycles(8);
    checks++;
    if (out_n !== 3) begin failures++; $display("FAIL single_count: got %0d expected 3", out_n); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_data[k] !== exp_d[k] || out_tid[k] !== 2'd2 || out_last[k] !== (k == 2) || out_cyc[k] !== k + 2) begin
        failures++;
        $display("FAIL single_beat%0d: got data=%h tid=%0d last=%b cyc=%0d expected data=%h tid=2 last=%b cyc=%0d",
                 k, out_data[k], out_tid[k], out_last[k], out_cyc[k], exp_d[k], (k == 2), k + 2);
      end
    end
    checks++;
    if (lg_mv[1] !== 1'b0 || lg_busy[0] !== 1'b0 || lg_busy[1] !== 1'b1 || lg_sr[1] !== 4'b0100) begin
      failures++;
      $display("FAIL single_latency: got mv1=%b busy0=%b busy1=%b sr1=%h expected 0/0/1/4", lg_mv[1], lg_busy[0], lg_busy[1], lg_sr[1]);
    end
    checks++;
    if (lg_busy[3] !== 1'b1 || lg_busy[4] !== 1'b0) begin
      failures++; $display("FAIL single_busy_fall: got busy3=%b busy4=%b expected 1/0", lg_busy[3], lg_busy[4]);
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] exp_d [4];
    logic [IW-1:0] exp_t [4];
    int            exp_c [4];
    exp_d[0] = 24'hA00001; exp_d[1] = 24'hA00002; exp_d[2] = 24'hD00001; exp_d[3] = 24'hD00002;
    exp_t[0] = 2'd0; exp_t[1] = 2'd0; exp_t[2] = 2'd3; exp_t[3] = 2'd3;
    exp_c[0] = 2; exp_c[1] = 3; exp_c[2] = 5; exp_c[3] = 6;
    do_reset();
    add_beat(0, 24'hA00001, 1'b0);
    add_beat(0, 24'hA00002, 1'b1);
    add_beat(3, 24'hD00001, 1'b0);
    add_beat(3, 24'hD00002, 1'b1);
    run_cycles(10);
    checks++;
    if (out_n !== 4) begin failures++; $display("FAIL simul_count: got %0d expected 4", out_n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_data[k] !== exp_d[k] || out_tid[k] !== exp_t[k] || out_cyc[k] !== exp_c[k]) begin
        failures++;
        $display("FAIL simul_beat%0d: got data=%h tid=%0d cyc=%0d expected data=%h tid=%0d cyc=%0d",
                 k, out_data[k], out_tid[k], out_cyc[k], exp_d[k], exp_t[k], exp_c[k]);
      end
    end
    checks++;
    if (lg_mv[4] !== 1'b0) begin failures++; $display("FAIL simul_gap: got mvalid=%b in cycle 4 expected 0", lg_mv[4]); end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int p = 0; p < N; p++)
      for (int k = 0; k < 3; k++)
        add_beat(p, 24'h100000 * (p + 1) + k, 1'b1);
    run_cycles(30);
    checks++;
    if (out_n !== 12) begin failures++; $display("FAIL fair_count: got %0d expected 12", out_n); end
    for (int j = 0; j < 12; j++) begin
      checks++;
      if (out_tid[j] !== IW'(j % 4) || out_data[j] !== DW'(24'h100000 * (j % 4 + 1) + j / 4)) begin
        failures++;
        $display("FAIL fair_pkt%0d: got tid=%0d data=%h expected tid=%0d data=%h",
                 j, out_tid[j], out_data[j], j % 4, 24'h100000 * (j % 4 + 1) + j / 4);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_d [4];
    int stalls;
    exp_d[0] = 24'h0000B1; exp_d[1] = 24'h0000B2; exp_d[2] = 24'h0000B3; exp_d[3] = 24'h0000B4;
    do_reset();
    mr_pat = 4'b1001;
    for (int k = 0; k < 4; k++) add_beat(1, exp_d[k], k == 3);
    run_cycles(20);
    checks++;
    if (out_n !== 4) begin failures++; $display("FAIL bp_count: got %0d expected 4", out_n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_data[k] !== exp_d[k] || out_last[k] !== (k == 3) || out_tid[k] !== 2'd1) begin
        failures++;
        $display("FAIL bp_beat%0d: got data=%h last=%b tid=%0d expected data=%h last=%b tid=1",
                 k, out_data[k], out_last[k], out_tid[k], exp_d[k], (k == 3));
      end
    end
    stalls = 0;
    for (int c = 0; c < 19; c++) begin
      if (lg_mv[c] && !lg_mr[c]) begin
        stalls++;
        checks++;
        if (lg_mv[c+1] !== 1'b1 || lg_md[c+1] !== lg_md[c] || lg_sr[c][1] !== 1'b0) begin
          failures++;
          $display("FAIL bp_stall_c%0d: got next_mv=%b next_data=%h sready1=%b expected 1 %h 0",
                   c, lg_mv[c+1], lg_md[c+1], lg_sr[c][1], lg_md[c]);
        end
      end
      checks++;
      if ($countones(lg_sr[c]) > 1) begin failures++; $display("FAIL bp_onehot_c%0d: got sready=%h expected at most one bit", c, lg_sr[c]); end
    end
    checks++;
    if (stalls !== 3) begin failures++; $display("FAIL bp_stall_count: got %0d expected 3", stalls); end
  endtask

  task automatic test_grant_lock();
    logic [IW-1:0] exp_t [5];
    exp_t[0] = 2'd0; exp_t[1] = 2'd0; exp_t[2] = 2'd0; exp_t[3] = 2'd0; exp_t[4] = 2'd1;
    do_reset();
    for (int k = 0; k < 4; k++) add_beat(0, 24'h0000C1 + k, k == 3);
    add_beat(1, 24'h0000E1, 1'b1);
    gap_at[0]  = 2;
    gap_len[0] = 5;
    run_cycles(16);
    for (int c = 0; c <= 10; c++) begin
      checks++;
      if (lg_sr[c][1] !== 1'b0) begin failures++; $display("FAIL lock_sready1_c%0d: got %b expected 0", c, lg_sr[c][1]); end
    end
    checks++;
    if (lg_sr[11][1] !== 1'b1) begin failures++; $display("FAIL lock_grant1: got %b expected 1", lg_sr[11][1]); end
    checks++;
    if (lg_busy[5] !== 1'b1 || lg_tid[5] !== 2'd0) begin failures++; $display("FAIL lock_hold: got busy=%b tid=%0d expected 1/0", lg_busy[5], lg_tid[5]); end
    checks++;
    if (out_n !== 5) begin failures++; $display("FAIL lock_count: got %0d expected 5", out_n); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_tid[k] !== exp_t[k]) begin failures++; $display("FAIL lock_tid%0d: got %0d expected %0d", k, out_tid[k], exp_t[k]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int k = 0; k < 4; k++) add_beat(0, 24'h0000F1 + k, k == 3);
    rst_cycle = 3;
    run_cycles(5);
    checks++;
    if (lg_mv[3] !== 1'b1 || lg_md[3] !== 24'h0000F2) begin failures++; $display("FAIL rstmid_pre: got mv=%b data=%h expected 1 0000f2", lg_mv[3], lg_md[3]); end
    checks++;
    if (lg_mv[4] !== 1'b0 || lg_md[4] !== 24'h0 || lg_ml[4] !== 1'b0 || lg_tid[4] !== 2'd0 || lg_busy[4] !== 1'b0 || lg_sr[4] !== 4'h0) begin
      failures++;
      $display("FAIL rstmid_outputs: got mv=%b data=%h last=%b tid=%0d busy=%b sr=%h expected all 0",
               lg_mv[4], lg_md[4], lg_ml[4], lg_tid[4], lg_busy[4], lg_sr[4]);
    end
    checks++;
    if (out_n !== 2) begin failures++; $display("FAIL rstmid_discard: got %0d beats expected 2", out_n); end
    out_n     = 0;
    rst_cycle = -1;
    pk_len[0] = 0;
    pk_ptr[0] = 0;
    add_beat(0, 24'h5A0001, 1'b0);
    add_beat(0, 24'h5A0002, 1'b1);
    run_cycles(6);
    checks++;
    if (out_n !== 2) begin failures++; $display("FAIL rstmid_after_count: got %0d expected 2", out_n); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_data[k] !== 24'h5A0001 + k || out_tid[k] !== 2'd0 || out_cyc[k] !== k + 2 || out_last[k] !== (k == 1)) begin
        failures++;
        $display("FAIL rstmid_after%0d: got data=%h tid=%0d cyc=%0d last=%b expected data=%h tid=0 cyc=%0d last=%b",
                 k, out_data[k], out_tid[k], out_cyc[k], out_last[k], 24'h5A0001 + k, k + 2, (k == 1));
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
    test_reset();
    test_single_source();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_grant_lock();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
